fetch_controller: RTL and testbench

Instruction-fetch sequencer for the byte-addressed, big-endian instruction memory (synchronous read, 1-cycle latency, MEM_BYTES bytes). It owns the program counter and drives the memory read address. It tracks the single in-flight read and presents fetched words to decode over a valid/ready handshake. It also handles redirects (branch/jump), halt, and illegal-address faults.

---
 rtl/fetch_controller.sv | 181 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for a byte-addressed,
// big-endian instruction memory with a synchronous 1-cycle read.
// Owns the program counter, tracks the one in-flight read, presents
// fetched words to decode, and handles redirect, halt and illegal-address faults.
//
// Handshake: if_valid_o/if_instr_o/if_pc_o are driven only from registers;
// a word moves to decode on a clock edge where if_valid_o & if_ready_i are
// both high, except when a redirect is taken in that same cycle, which
// squashes the slot and the in-flight read (that handshake is not a transfer).
// if_valid_o never drops without either a transfer or a redirect, and the
// slot contents stay stable while if_valid_o & !if_ready_i.
module fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        fault_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Highest legal word address in memory.
  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

  // Word-aligned and inside memory (unsigned compare, so wrapped PCs fail).
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  state_e      state_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic        fault_q;

  logic not_fault;
  logic slot_free;
  logic redir;
  logic redir_legal;
  logic fetch_legal;
  logic accept;
  logic issue_slot;
  logic issue;
  logic issue_fault;
  logic redir_issue;
  logic redir_park;
  logic redir_fault;
  logic stall;
  logic go_fault;

  // Per-cycle decisions: what happens to the slot, the in-flight read and the PC.
  always_comb begin
    not_fault   = (state_q != ST_FAULT);
    slot_free   = !if_valid_q || if_ready_i;
    // Once faulted, redirects are ignored entirely.
    redir       = redirect_valid_i && not_fault;
    redir_legal = addr_legal(redirect_pc_i);
    fetch_legal = addr_legal(fetch_pc_q);
    // Capture the returning word into the slot unless a redirect squashes it.
    accept      = inflight_q && slot_free && !redir;
    // A new read may go out if nothing is in flight or the in-flight word
    // leaves this cycle. HALT with halt low resumes issuing immediately.
    issue_slot  = not_fault && !halt_i && !redir && (!inflight_q || accept);
    issue       = issue_slot && fetch_legal;
    issue_fault = issue_slot && !fetch_legal;
    redir_issue = redir && !halt_i && redir_legal;
    redir_park  = redir && halt_i && redir_legal;
    redir_fault = redir && !redir_legal;
    // Slot full and not draining: the in-flight word must be re-read.
    stall       = inflight_q && !slot_free;
    go_fault    = issue_fault || redir_fault;
  end

  // Memory address: new target, next sequential word, or replay of the stalled word.
  always_comb begin
    if (redir_issue) begin
      imem_addr_o = redirect_pc_i;
    end else if (issue) begin
      imem_addr_o = fetch_pc_q;
    end else if (stall) begin
      imem_addr_o = inflight_pc_q;
    end else begin
      imem_addr_o = fetch_pc_q;
    end
  end

  // Next values of the fetch PC and the in-flight read tracker.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    if (redir_issue) begin
      fetch_pc_d    = redirect_pc_i + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_pc_i;
    end else if (redir_park) begin
      fetch_pc_d = redirect_pc_i;
      inflight_d = 1'b0;
    end else if (redir) begin
      // Illegal redirect target: squash only, no read.
      inflight_d = 1'b0;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end else if (accept) begin
      inflight_d = 1'b0;
    end
  end

  // Control FSM plus all registered state and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      fault_q       <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;

      case (state_q)
        ST_RUN, ST_HALT: begin
          if (go_fault) begin
            state_q <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (halt_i) begin
            state_q <= ST_HALT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          // FAULT is left only through reset.
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
      endcase

      if (redir) begin
        if_valid_q <= 1'b0;
      end else if (accept) begin
        if_valid_q <= 1'b1;
        if_instr_q <= imem_data_i;
        if_pc_q    <= inflight_pc_q;
      end else if (slot_free) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  assign if_valid_o = if_valid_q;
  assign if_instr_o = if_instr_q;
  assign if_pc_o    = if_pc_q;
  assign fault_o    = fault_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed timing checks of fetch_controller plus a
// randomized run compared against a transaction-level model of the
// delivered instruction stream.
module tb_fetch_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [1:0]  state_dbg;

  fetch_controller #(
    .RESET_PC (32'h0),
    .MEM_BYTES(256)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr_o     (imem_addr),
    .imem_data_i     (imem_data),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .halt_i          (halt),
    .if_valid_o      (if_valid),
    .if_ready_i      (if_ready),
    .if_instr_o      (if_instr),
    .if_pc_o         (if_pc),
    .fault_o         (fault),
    .state_o         (state_dbg)
  );

  // Instruction memory: 64 words, synchronous read, 1-cycle latency.
  logic [31:0] mem [0:63];
  always @(posedge clk) imem_data <= mem[imem_addr[7:2]];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic restart();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    if_ready       = 1'b1;
    rst_n          = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic slot(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(if_valid), 32'd1);
    check_eq({tag, "_pc"}, if_pc, pc);
    check_eq({tag, "_instr"}, if_instr, word_at(pc));
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] e;
  logic [31:0] exp_pc;
  int          since;
  int          xfers;
  logic        do_redir;
  logic        seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2149_0064;

    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    if_ready       = 1'b1;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);

    // ---- reset release and steady stream ----
    step();
    step();
    rst_n = 1'b1;
    #1 check_eq("first_addr", imem_addr, 32'h0);
    step();
    check_eq("edge1_valid", 32'(if_valid), 32'd0);
    check_eq("edge1_addr", imem_addr, 32'h4);
    step();
    slot("edge2", 32'h0);
    check_eq("edge2_instr_const", if_instr, 32'h2149_0064);
    check_eq("edge2_addr", imem_addr, 32'h8);
    step();
    slot("edge3", 32'h4);

    // ---- backpressure: slot and address held ----
    if_ready = 1'b0;
    #1 check_eq("stall_addr0", imem_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      step();
      slot("stall_hold", 32'h4);
      check_eq("stall_addr", imem_addr, 32'h8);
    end
    if_ready = 1'b1;
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      slot("post_stall", e);
    end

    // ---- redirect while a transfer is offered ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1 check_eq("redir_addr", imem_addr, 32'h40);
    step();
    redirect_valid = 1'b0;
    check_eq("redir_squash", 32'(if_valid), 32'd0);
    step();
    slot("redir_t0", 32'h40);
    step();
    slot("redir_t1", 32'h44);

    // ---- halt for 4 cycles ----
    halt = 1'b1;
    step();
    slot("halt_drain", 32'h48);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("halt_idle", 32'(if_valid), 32'd0);
    end
    halt = 1'b0;
    step();
    check_eq("resume_gap", 32'(if_valid), 32'd0);
    step();
    slot("resume_t0", 32'h4C);
    step();
    slot("resume_t1", 32'h50);

    // ---- asynchronous reset mid-stream ----
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(if_valid), 32'd0);
    check_eq("async_pc", if_pc, 32'h0);
    check_eq("async_instr", if_instr, 32'h0);
    check_eq("async_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    slot("restart", 32'h0);

    // ---- misaligned redirect faults ----
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    check_eq("misalign_fault", 32'(fault), 32'd1);
    check_eq("misalign_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("fault_quiet", 32'(if_valid), 32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("fault_ignore_redir", 32'(if_valid), 32'd0);
      check_eq("fault_sticky", 32'(fault), 32'd1);
    end

    // ---- running off the end of memory ----
    restart();
    step();
    step();
    slot("eom_start", 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hF8;
    step();
    redirect_valid = 1'b0;
    check_eq("eom_squash", 32'(if_valid), 32'd0);
    check_eq("eom_fault0", 32'(fault), 32'd0);
    step();
    slot("eom_f8", 32'hF8);
    check_eq("eom_fault1", 32'(fault), 32'd0);
    step();
    slot("eom_fc", 32'hFC);
    check_eq("eom_fault2", 32'(fault), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("eom_quiet", 32'(if_valid), 32'd0);
    end

    // ---- randomized run against the stream model ----
    // Model: decode sees consecutive words starting at the last redirect
    // target (or RESET_PC); a redirect discards anything not yet taken.
    restart();
    exp_pc = 32'h0;
    since  = 0;
    xfers  = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      check_eq("rand_no_fault", 32'(fault), 32'd0);
      if_ready = ($urandom_range(0, 3) != 0);
      halt     = ($urandom_range(0, 7) == 0);
      do_redir = (since >= 12) || ($urandom_range(0, 19) == 0);
      redirect_valid = do_redir;
      redirect_pc    = 32'($urandom_range(0, 32)) << 2;
      if (if_valid && if_ready && !do_redir) begin
        check_eq("rand_pc", if_pc, exp_pc);
        check_eq("rand_instr", if_instr, word_at(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      if (do_redir) begin
        exp_pc = redirect_pc;
        since  = 0;
      end else begin
        since++;
      end
    end
    step();
    redirect_valid = 1'b0;
    halt           = 1'b0;
    if_ready       = 1'b1;
    seen           = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (if_valid) begin
        check_eq("drain_pc", if_pc, exp_pc);
        check_eq("drain_instr", if_instr, word_at(exp_pc));
        seen = 1'b1;
      end else begin
        step();
      end
    end
    check_eq("drain_timeout", 32'(seen), 32'd1);
    check_eq("rand_progress", 32'(xfers > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
